// File: rtl/wb_host_master.sv
// -----------------------------------------------------------------------------
// wb_host_master
// Wishbone classic single-transfer master. A command accepted on the
// valid/ready command channel becomes exactly one Wishbone read or write
// cycle. The outcome is returned on a valid/ready response channel. If the
// slave never acknowledges, a watchdog ends the cycle with an error response,
// so the bus cannot hang.
//
// Ports
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o    command handshake (ready only while idle)
//   cmd_we_i, cmd_adr_i,
//   cmd_dat_i, cmd_sel_i         command payload
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_dat_o, rsp_err_o         read data (0 for writes/errors), timeout flag
//   wbm_*                        Wishbone master side
// -----------------------------------------------------------------------------
module wb_host_master #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic [DW-1:0]   cmd_dat_i,
    input  logic [DW/8-1:0] cmd_sel_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_dat_o,
    output logic            rsp_err_o,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic            wbm_ack_i,
    input  logic [DW-1:0]   wbm_dat_i
);

    localparam int unsigned SW       = DW / 8;
    localparam int unsigned CW       = (TIMEOUT > 32'd0) ? $clog2(TIMEOUT + 32'd1) : 1;
    localparam bit          WD_EN    = (TIMEOUT != 32'd0);
    // Counter value on the last permitted wait edge; stb is then high for exactly TIMEOUT cycles.
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 32'd0) ? (TIMEOUT - 32'd1) : 32'd0);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
    logic            rsp_err_q, rsp_err_d;

    // Next-state and next-output logic of the transfer FSM.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    sel_d   = cmd_sel_i;
                    cyc_d   = 1'b1;
                    cnt_d   = {CW{1'b0}};
                    state_d = BUS;
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                // Ack is tested first so an ack on the timeout edge still completes normally.
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_dat_d   = we_q ? {DW{1'b0}} : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (WD_EN && (cnt_q == CNT_LAST)) begin
                    cyc_d       = 1'b0;
                    rsp_dat_d   = {DW{1'b0}};
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CW'(1));
                    state_d = BUS;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers; async reset drops the bus cycle immediately.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= {AW{1'b0}};
            dat_q       <= {DW{1'b0}};
            sel_q       <= {SW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= {DW{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Classic single transfers: stb always tracks cyc.
    assign cmd_ready_o = (state_q == IDLE);
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_host_master.sv
// -----------------------------------------------------------------------------
// tb_wb_host_master
// Directed bench for wb_host_master (TIMEOUT=4): write with one wait state,
// zero-wait read, watchdog timeout, response backpressure, asynchronous reset
// in the middle of a bus cycle, and an ack on the timeout edge.
// -----------------------------------------------------------------------------
module tb_wb_host_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_o;
    logic        ack;
    logic [31:0] dat_i;

    int tests_run = 0;
    int fails     = 0;
    int stb_cnt;

    wb_host_master #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_we_i   (cmd_we),
        .cmd_adr_i  (cmd_adr),
        .cmd_dat_i  (cmd_dat),
        .cmd_sel_i  (cmd_sel),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_dat_o  (rsp_dat),
        .rsp_err_o  (rsp_err),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we),
        .wbm_sel_o  (sel),
        .wbm_adr_o  (adr),
        .wbm_dat_o  (dat_o),
        .wbm_ack_i  (ack),
        .wbm_dat_i  (dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_we    = w;
        cmd_adr   = a;
        cmd_dat   = d;
        cmd_sel   = s;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'd0;
        cmd_dat = 32'd0; cmd_sel = 4'd0; rsp_ready = 1'b1; ack = 1'b0; dat_i = 32'd0;
        #3;
        check_val("rst_cyc",       {63'd0, cyc},       64'd0);
        check_val("rst_stb",       {63'd0, stb},       64'd0);
        check_val("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_val("rst_rsp_dat",   {32'd0, rsp_dat},   64'd0);
        check_val("rst_rsp_err",   {63'd0, rsp_err},   64'd0);
        check_val("rst_adr",       {32'd0, adr},       64'd0);
        check_val("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        step();
        rst_n = 1'b1;
        step();

        // Write to a one-wait slave.
        issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        check_val("wr_cyc1",  {63'd0, cyc},       64'd1);
        check_val("wr_stb1",  {63'd0, stb},       64'd1);
        check_val("wr_we",    {63'd0, we},        64'd1);
        check_val("wr_adr",   {32'd0, adr},       64'h3000_0004);
        check_val("wr_dat",   {32'd0, dat_o},     64'hDEAD_BEEF);
        check_val("wr_sel",   {60'd0, sel},       64'hF);
        check_val("wr_ready", {63'd0, cmd_ready}, 64'd0);
        step();
        check_val("wr_stb2",  {63'd0, stb},       64'd1);
        check_val("wr_adr2",  {32'd0, adr},       64'h3000_0004);
        ack = 1'b1; dat_i = 32'hFFFF_FFFF;
        step();
        ack = 1'b0;
        check_val("wr_stb_end",   {63'd0, stb},       64'd0);
        check_val("wr_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check_val("wr_rsp_dat",   {32'd0, rsp_dat},   64'd0);
        check_val("wr_rsp_err",   {63'd0, rsp_err},   64'd0);
        step();
        check_val("wr_done_valid", {63'd0, rsp_valid}, 64'd0);
        check_val("wr_done_ready", {63'd0, cmd_ready}, 64'd1);

        // Read from a zero-wait slave.
        issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
        check_val("rd_stb",   {63'd0, stb},       64'd1);
        check_val("rd_we",    {63'd0, we},        64'd0);
        check_val("rd_ready", {63'd0, cmd_ready}, 64'd0);
        ack = 1'b1; dat_i = 32'h1234_5678;
        step();
        ack = 1'b0; dat_i = 32'h0;
        check_val("rd_stb_end",   {63'd0, stb},       64'd0);
        check_val("rd_ready2",    {63'd0, cmd_ready}, 64'd0);
        check_val("rd_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check_val("rd_rsp_dat",   {32'd0, rsp_dat},   64'h1234_5678);
        check_val("rd_adr_hold",  {32'd0, adr},       64'h3000_0008);
        step();
        check_val("rd_done_ready", {63'd0, cmd_ready}, 64'd1);

        // Watchdog timeout: slave never acks.
        issue(1'b0, 32'h3000_0010, 32'h0, 4'h3);
        stb_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (stb) begin
                stb_cnt++;
                step();
            end else begin
                break;
            end
        end
        check_val("to_stb_cycles", stb_cnt,               64'd4);
        check_val("to_rsp_valid",  {63'd0, rsp_valid},    64'd1);
        check_val("to_rsp_err",    {63'd0, rsp_err},      64'd1);
        check_val("to_rsp_dat",    {32'd0, rsp_dat},      64'd0);
        step();
        ack = 1'b1; dat_i = 32'h5555_5555;
        step();
        ack = 1'b0;
        check_val("idle_ack_cyc",   {63'd0, cyc},       64'd0);
        check_val("idle_ack_valid", {63'd0, rsp_valid}, 64'd0);
        check_val("idle_ack_ready", {63'd0, cmd_ready}, 64'd1);

        // Response backpressure with a second command waiting.
        rsp_ready = 1'b0;
        issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        ack = 1'b1; dat_i = 32'hCAFE_0001;
        step();
        ack = 1'b0; dat_i = 32'h0;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0024;
        cmd_dat = 32'h0000_00AA; cmd_sel = 4'h1;
        for (int i = 0; i < 5; i++) begin
            check_val("bp_valid", {63'd0, rsp_valid}, 64'd1);
            check_val("bp_dat",   {32'd0, rsp_dat},   64'hCAFE_0001);
            check_val("bp_ready", {63'd0, cmd_ready}, 64'd0);
            check_val("bp_cyc",   {63'd0, cyc},       64'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        check_val("bp_rel_valid", {63'd0, rsp_valid}, 64'd0);
        check_val("bp_rel_cyc",   {63'd0, cyc},       64'd0);
        check_val("bp_rel_ready", {63'd0, cmd_ready}, 64'd1);
        step();
        cmd_valid = 1'b0;
        check_val("bp2_cyc", {63'd0, cyc},   64'd1);
        check_val("bp2_adr", {32'd0, adr},   64'h3000_0024);
        check_val("bp2_we",  {63'd0, we},    64'd1);
        check_val("bp2_dat", {32'd0, dat_o}, 64'hAA);
        ack = 1'b1; dat_i = 32'h1111_1111;
        step();
        ack = 1'b0;
        check_val("bp2_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check_val("bp2_rsp_dat",   {32'd0, rsp_dat},   64'd0);
        step();

        // Asynchronous reset in the third wait cycle.
        issue(1'b0, 32'h3000_0030, 32'h0, 4'hF);
        step();
        step();
        check_val("ar_pre_stb", {63'd0, stb}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("ar_cyc",   {63'd0, cyc},       64'd0);
        check_val("ar_stb",   {63'd0, stb},       64'd0);
        check_val("ar_valid", {63'd0, rsp_valid}, 64'd0);
        check_val("ar_ready", {63'd0, cmd_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_val("ar_post_ready", {63'd0, cmd_ready}, 64'd1);
        check_val("ar_post_valid", {63'd0, rsp_valid}, 64'd0);
        issue(1'b0, 32'h3000_0034, 32'h0, 4'hF);
        ack = 1'b1; dat_i = 32'h0BAD_F00D;
        step();
        ack = 1'b0;
        check_val("ar_rd_valid", {63'd0, rsp_valid}, 64'd1);
        check_val("ar_rd_dat",   {32'd0, rsp_dat},   64'h0BAD_F00D);
        check_val("ar_rd_err",   {63'd0, rsp_err},   64'd0);
        step();

        // Ack arriving on the timeout edge (fourth stb cycle).
        issue(1'b0, 32'h3000_0040, 32'h0, 4'hF);
        step();
        step();
        step();
        check_val("ate_stb4", {63'd0, stb}, 64'd1);
        ack = 1'b1; dat_i = 32'hA5A5_A5A5;
        step();
        ack = 1'b0;
        check_val("ate_valid", {63'd0, rsp_valid}, 64'd1);
        check_val("ate_err",   {63'd0, rsp_err},   64'd0);
        check_val("ate_dat",   {32'd0, rsp_dat},   64'hA5A5_A5A5);
        check_val("ate_stb",   {63'd0, stb},       64'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
